// File: rtl/mips_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, grant
// encoding and the grant priority function.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    // MEM has fixed priority unless the starvation guard forces IF through.
    function automatic grant_t pick_grant(input logic if_req,
                                          input logic mem_req,
                                          input logic force_if);
        grant_t g;
        g = GNT_NONE;
        if (force_if && if_req && mem_req) begin
            g = GNT_IF;
        end else if (mem_req) begin
            g = GNT_MEM;
        end else if (if_req) begin
            g = GNT_IF;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter for the memory port arbiter. Counts consecutive MEM
// grants made while IF was waiting and raises force_if once the count
// reaches LIMIT. Only used when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_grant,
    input  logic if_grant,
    input  logic if_req,
    output logic force_if
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Saturating count of MEM grants that overtook a pending fetch.
    always_comb begin
        count_next = count_reg;
        if (if_grant) begin
            count_next = '0;
        end else if (mem_grant) begin
            if (if_req) begin
                count_next = (count_reg == LIMIT_V) ? count_reg : count_reg + 1'b1;
            end else begin
                count_next = '0;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign force_if = (count_reg == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF (fetch) and MEM
// (load/store) pipeline stages. One transaction at a time: grant in IDLE,
// hold the memory request through wait states, ack the winner for one cycle.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        state_reg, state_next;
    grant_t            grant;
    logic              force_if;

    logic              ram_req_reg, ram_req_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
    logic              if_ack_reg, if_ack_next;
    logic              mem_ack_reg, mem_ack_next;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .mem_grant(grant == GNT_MEM),
        .if_grant (grant == GNT_IF),
        .if_req   (if_req),
        .force_if (force_if)
    );
`else
    // No guard: strict MEM priority. A limit can never be negative, so this
    // is constant 0; it keeps the unused limit tied into the design.
    assign force_if = (STARVE_LIMIT < 0);
`endif

    // Next-state and datapath: grant in IDLE, wait for ram_ready, ack in RESP.
    always_comb begin
        state_next     = state_reg;
        grant          = GNT_NONE;
        ram_req_next   = ram_req_reg;
        ram_we_next    = ram_we_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        if_ack_next    = 1'b0;
        mem_ack_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                grant = pick_grant(if_req, mem_req, force_if);
                if (grant == GNT_MEM) begin
                    state_next     = BUSY_MEM;
                    ram_req_next   = 1'b1;
                    ram_we_next    = mem_we;
                    ram_addr_next  = mem_addr;
                    ram_wdata_next = mem_wdata;
                end else if (grant == GNT_IF) begin
                    state_next    = BUSY_IF;
                    ram_req_next  = 1'b1;
                    ram_we_next   = 1'b0;
                    ram_addr_next = if_addr;
                end
            end
            BUSY_IF: begin
                if (ram_ready) begin
                    state_next    = RESP;
                    ram_req_next  = 1'b0;
                    ram_we_next   = 1'b0;
                    if_rdata_next = ram_rdata;
                    if_ack_next   = 1'b1;
                end
            end
            BUSY_MEM: begin
                if (ram_ready) begin
                    state_next     = RESP;
                    ram_req_next   = 1'b0;
                    ram_we_next    = 1'b0;
                    mem_rdata_next = ram_rdata;
                    mem_ack_next   = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                ram_req_next = 1'b0;
                ram_we_next  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ram_req_reg   <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            mem_ack_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ram_req_reg   <= ram_req_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            if_rdata_reg  <= if_rdata_next;
            mem_rdata_reg <= mem_rdata_next;
            if_ack_reg    <= if_ack_next;
            mem_ack_reg   <= mem_ack_next;
        end
    end

    assign ram_req   = ram_req_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;
    assign if_ack    = if_ack_reg;
    assign mem_ack   = mem_ack_reg;

    assign stall_if  = if_req & ~if_ack_reg;
    assign stall_mem = mem_req & ~mem_ack_reg;

endmodule
